// File: rtl/bk_adder_pipe.sv
// Purpose : pipelined WIDTH-bit add/subtract using a Brent-Kung parallel-prefix carry network.
// Latency : 3 cycles from acceptance to out_valid with no stalls; one transaction per cycle.
// Backpr. : whole pipe advances when the output slot is empty or drained; in_ready follows out_ready combinationally.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_ops[2*WIDTH-1:0]     interleaved operands: in_ops[2i]=a[i], in_ops[2i+1]=b[i]
//   in_sub                  1 = a-b (a+~b+1, cin ignored), 0 = a+b+cin
//   cin                     carry-in for add mode (honoured only when USE_CIN != 0)
//   in_valid / in_ready     input handshake
//   out_sum[WIDTH:0]        result, bit WIDTH is carry-out (sub mode: 1 = no borrow)
//   out_ovf                 signed two's-complement overflow of the WIDTH-bit result
//   out_valid / out_ready   output handshake
//
// Pipeline
//   capture : de-interleaved operands a, b' (b inverted in sub mode) and carry-in c0
//   S1      : per-bit generate/propagate, c0, operand MSBs
//   S2      : Brent-Kung up-sweep group (G,P) terms
//   S3      : down-sweep, carry formation, sum and overflow (output register)

module bk_adder_pipe #(
    parameter int WIDTH   = 12,
    parameter int USE_CIN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] in_ops,
    input  logic               in_sub,
    input  logic               cin,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH:0]     out_sum,
    output logic               out_ovf,
    output logic               out_valid,
    input  logic               out_ready
);

    // The prefix tree is built over the next power of two; positions at and
    // above WIDTH are padding with g=0, p=0.
    localparam int LG = $clog2(WIDTH);
    localparam int NP = 1 << LG;

    // ------------------------------------------------------------------
    // Flow control: a single advance strobe moves every stage together.
    // ------------------------------------------------------------------
    logic w_adv;

    logic             r_in_vld;
    logic [WIDTH-1:0] r_in_a;
    logic [WIDTH-1:0] r_in_b;
    logic             r_in_c0;

    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_g;
    logic [WIDTH-1:0] r_s1_p;
    logic             r_s1_c0;
    logic             r_s1_am;
    logic             r_s1_bm;

    logic             r_s2_vld;
    logic [WIDTH-1:0] r_s2_gg;   // up-sweep group generate
    logic [WIDTH-1:0] r_s2_gp;   // up-sweep group propagate
    logic [WIDTH-1:0] r_s2_p;    // raw per-bit propagate, needed for the sum
    logic             r_s2_c0;
    logic             r_s2_am;
    logic             r_s2_bm;

    logic             r_s3_vld;
    logic [WIDTH:0]   r_s3_sum;
    logic             r_s3_ovf;

    assign w_adv    = ~r_s3_vld | out_ready;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // Operand de-interleave and effective operand / carry-in selection.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_c0;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_a[i] = in_ops[2*i];
            // Subtraction is a + ~b + 1: invert b here, force the carry-in below.
            w_b[i] = in_ops[2*i+1] ^ in_sub;
        end
    end

    assign w_c0 = in_sub | ((USE_CIN != 0) ? cin : 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_vld <= 1'b0;
            r_in_a   <= '0;
            r_in_b   <= '0;
            r_in_c0  <= 1'b0;
        end else if (w_adv) begin
            r_in_vld <= in_valid;
            r_in_a   <= w_a;
            r_in_b   <= w_b;
            r_in_c0  <= w_c0;
        end
    end

    // ------------------------------------------------------------------
    // S1: per-bit generate / propagate.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_g   <= '0;
            r_s1_p   <= '0;
            r_s1_c0  <= 1'b0;
            r_s1_am  <= 1'b0;
            r_s1_bm  <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld <= r_in_vld;
            r_s1_g   <= r_in_a & r_in_b;
            r_s1_p   <= r_in_a ^ r_in_b;
            r_s1_c0  <= r_in_c0;
            r_s1_am  <= r_in_a[WIDTH-1];
            r_s1_bm  <= r_in_b[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Up-sweep. At level k, node j with (j+1) a multiple of 2^k absorbs the
    // node 2^(k-1) below it. Updated nodes at one level are never read at the
    // same level, so the in-place update is safe. Nodes below WIDTH depend
    // only on lower bits, so the padding never reaches the kept slice.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_up_g;
    logic [WIDTH-1:0] w_up_p;

    always_comb begin : up_sweep
        logic [NP-1:0] g;
        logic [NP-1:0] p;
        g              = '0;
        p              = '0;
        g[WIDTH-1:0]   = r_s1_g;
        p[WIDTH-1:0]   = r_s1_p;
        for (int k = 1; k <= LG; k++) begin
            for (int j = (1 << k) - 1; j < NP; j += (1 << k)) begin
                // (G,P)hi o (G,P)lo = (Ghi | Phi&Glo, Phi&Plo); G uses the old Phi.
                g[j] = g[j] | (p[j] & g[j-(1<<(k-1))]);
                p[j] = p[j] & p[j-(1<<(k-1))];
            end
        end
        w_up_g = g[WIDTH-1:0];
        w_up_p = p[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_gg  <= '0;
            r_s2_gp  <= '0;
            r_s2_p   <= '0;
            r_s2_c0  <= 1'b0;
            r_s2_am  <= 1'b0;
            r_s2_bm  <= 1'b0;
        end else if (w_adv) begin
            r_s2_vld <= r_s1_vld;
            r_s2_gg  <= w_up_g;
            r_s2_gp  <= w_up_p;
            r_s2_p   <= r_s1_p;
            r_s2_c0  <= r_s1_c0;
            r_s2_am  <= r_s1_am;
            r_s2_bm  <= r_s1_bm;
        end
    end

    // ------------------------------------------------------------------
    // Down-sweep. At level k (from LG-1 down to 1), node j with
    // (j+1) mod 2^k == 2^(k-1) and j >= 2^k absorbs the full prefix held at
    // j - 2^(k-1). Afterwards node i holds (G,P) over bits [0..i], and the
    // carry into bit i+1 is G | P&c0.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    always_comb begin : down_sweep
        logic [NP-1:0]  g;
        logic [NP-1:0]  p;
        logic [WIDTH:0] c;
        g              = '0;
        p              = '0;
        g[WIDTH-1:0]   = r_s2_gg;
        p[WIDTH-1:0]   = r_s2_gp;
        for (int k = LG - 1; k >= 1; k--) begin
            for (int j = (1 << k) + (1 << (k-1)) - 1; j < NP; j += (1 << k)) begin
                g[j] = g[j] | (p[j] & g[j-(1<<(k-1))]);
                p[j] = p[j] & p[j-(1<<(k-1))];
            end
        end
        c    = '0;
        c[0] = r_s2_c0;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & r_s2_c0);
        end
        w_sum  = r_s2_p ^ c[WIDTH-1:0];
        w_cout = c[WIDTH];
    end

    // Same-signed effective operands producing a result of the other sign;
    // this is identical to c[WIDTH] ^ c[WIDTH-1] and reuses the saved MSBs.
    assign w_ovf = (r_s2_am ~^ r_s2_bm) & (w_sum[WIDTH-1] ^ r_s2_am);

    // ------------------------------------------------------------------
    // S3: output register. Empty slots load zeros so the outputs read 0
    // whenever out_valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_vld <= 1'b0;
            r_s3_sum <= '0;
            r_s3_ovf <= 1'b0;
        end else if (w_adv) begin
            r_s3_vld <= r_s2_vld;
            r_s3_sum <= r_s2_vld ? {w_cout, w_sum} : '0;
            r_s3_ovf <= r_s2_vld & w_ovf;
        end
    end

    assign out_valid = r_s3_vld;
    assign out_sum   = r_s3_sum;
    assign out_ovf   = r_s3_ovf;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Purpose : self-checking bench for bk_adder_pipe: directed cases, stall stream, mid-stream reset, width sweep.
// Latency : expects results 3 cycles after acceptance; compares every drained output against an arithmetic model.
// Backpr. : drives random out_ready and checks held outputs stay stable while stalled.

module tb_bk_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int fails    = 0;
    int done_cnt = 0;

    logic rst_n;
    logic s_rst_n;

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference: {ovf, sum[64:0]}. Sum from unsigned arithmetic, ovf from the
    // true signed result falling outside the WIDTH-bit signed range.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic sub, input logic c);
        logic [64:0]        s;
        logic signed [67:0] sa, sb, t, lim;
        logic               ovf;
        if (sub) s = {1'b0, a} + (65'd1 << w) - {1'b0, b};
        else     s = {1'b0, a} + {1'b0, b} + {64'd0, c};
        sa = $signed({4'd0, a});
        if (a[w-1]) sa = sa - (68'sd1 <<< w);
        sb = $signed({4'd0, b});
        if (b[w-1]) sb = sb - (68'sd1 <<< w);
        if (sub) t = sa - sb;
        else begin
            t = sa + sb;
            if (c) t = t + 68'sd1;
        end
        lim = 68'sd1 <<< (w - 1);
        ovf = (t >= lim) || (t < -lim);
        return {ovf, s};
    endfunction

    function automatic logic [127:0] pack(input int w, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Main instance: WIDTH=12, USE_CIN=1
    // ------------------------------------------------------------------
    logic [23:0] m_ops;
    logic        m_sub, m_cin, m_vld, m_rdy, m_ovf, m_ovld, m_ordy;
    logic [12:0] m_sum;
    logic [63:0] m_a, m_b;
    logic [65:0] mq[$];
    int          m_outs = 0;
    logic        m_held = 1'b0;
    logic [65:0] m_hold_val = '0;

    bk_adder_pipe #(.WIDTH(12), .USE_CIN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_ops(m_ops), .in_sub(m_sub), .cin(m_cin),
        .in_valid(m_vld), .in_ready(m_rdy), .out_sum(m_sum), .out_ovf(m_ovf),
        .out_valid(m_ovld), .out_ready(m_ordy)
    );

    // USE_CIN=0 instance for the ignored carry-in case
    logic [23:0] n_ops;
    logic        n_sub, n_cin, n_vld, n_rdy, n_ovf, n_ovld, n_ordy;
    logic [12:0] n_sum;

    bk_adder_pipe #(.WIDTH(12), .USE_CIN(0)) u_nc (
        .clk(clk), .rst_n(rst_n), .in_ops(n_ops), .in_sub(n_sub), .cin(n_cin),
        .in_valid(n_vld), .in_ready(n_rdy), .out_sum(n_sum), .out_ovf(n_ovf),
        .out_valid(n_ovld), .out_ready(n_ordy)
    );

    always @(negedge clk) begin : m_mon
        logic [65:0] pk;
        logic [65:0] e;
        pk        = '0;
        pk[12:0]  = m_sum;
        pk[65]    = m_ovf;
        if (rst_n) begin
            if (m_held) chk("main_stall_hold", {1'b0, m_ovld, pk}, {1'b0, 1'b1, m_hold_val});
            if (m_ovld) begin
                if (m_ordy) begin
                    if (mq.size() == 0) chk("main_unexpected_out", 1, 0);
                    else begin
                        e = mq.pop_front();
                        chk("main_result", pk, e);
                        m_outs++;
                    end
                end
            end else begin
                chk("main_idle_zero", pk, 0);
            end
            m_held     = m_ovld && !m_ordy;
            m_hold_val = pk;
            if (m_vld && m_rdy) mq.push_back(ref_add(12, m_a, m_b, m_sub, m_cin));
        end else begin
            m_held = 1'b0;
        end
    end

    task automatic drive_main(input logic [11:0] a, input logic [11:0] b, input logic sub, input logic c);
        logic [127:0] t;
        m_a   = {52'd0, a};
        m_b   = {52'd0, b};
        m_sub = sub;
        m_cin = c;
        t     = pack(12, m_a, m_b);
        m_ops = t[23:0];
    endtask

    task automatic directed(input logic [11:0] a, input logic [11:0] b, input logic sub, input logic c,
                            input logic [12:0] es, input logic eo, input string nm);
        int lat;
        lat = -1;
        @(posedge clk);
        #1;
        drive_main(a, b, sub, c);
        m_vld  = 1'b1;
        m_ordy = 1'b1;
        @(posedge clk);
        #1;
        m_vld = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (m_ovld) begin
                lat = k - 1;
                break;
            end
        end
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_sum"}, m_sum, es);
        chk({nm, "_ovf"}, m_ovf, eo);
    endtask

    // ------------------------------------------------------------------
    // Width sweep: independent instances, random ops and random out_ready
    // ------------------------------------------------------------------
    initial begin
        s_rst_n = 1'b0;
        #23;
        s_rst_n = 1'b1;
    end

    function automatic logic [63:0] pick(input int w, input logic [63:0] mask);
        case ($urandom_range(0, 7))
            0:       return mask;
            1:       return 64'd1 << (w - 1);
            2:       return (64'd1 << (w - 1)) - 64'd1;
            3:       return 64'd0;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    for (genvar gi = 0; gi < 5; gi++) begin : g_sw
        localparam int W  = (gi == 0) ? 2 : (gi == 1) ? 7 : (gi == 2) ? 12 : (gi == 3) ? 32 : 64;
        localparam int UC = (gi == 1) ? 0 : 1;
        localparam int NTX = 10000;

        logic [2*W-1:0] ops;
        logic           sub, cin, vld, rdy, ovf, ovld, ordy;
        logic [W:0]     sum;
        logic [63:0]    ca, cb;
        logic [65:0]    q[$];
        logic           held = 1'b0;
        logic [65:0]    hv = '0;

        bk_adder_pipe #(.WIDTH(W), .USE_CIN(UC)) u_sw (
            .clk(clk), .rst_n(s_rst_n), .in_ops(ops), .in_sub(sub), .cin(cin),
            .in_valid(vld), .in_ready(rdy), .out_sum(sum), .out_ovf(ovf),
            .out_valid(ovld), .out_ready(ordy)
        );

        always @(negedge clk) begin : mon
            logic [65:0] pk;
            logic [65:0] e;
            pk       = '0;
            pk[W:0]  = sum;
            pk[65]   = ovf;
            if (s_rst_n) begin
                if (held) chk($sformatf("w%0d_stall_hold", W), {1'b0, ovld, pk}, {1'b0, 1'b1, hv});
                if (ovld) begin
                    if (ordy) begin
                        if (q.size() == 0) chk($sformatf("w%0d_unexpected_out", W), 1, 0);
                        else begin
                            e = q.pop_front();
                            chk($sformatf("w%0d_result", W), pk, e);
                        end
                    end
                end else begin
                    chk($sformatf("w%0d_idle_zero", W), pk, 0);
                end
                held = ovld && !ordy;
                hv   = pk;
                if (vld && rdy) q.push_back(ref_add(W, ca, cb, sub, (UC != 0) ? cin : 1'b0));
            end
        end

        initial begin : drv
            int           sent;
            logic         acc;
            logic [63:0]  mask;
            logic [127:0] t;
            sent = 0;
            acc  = 1'b0;
            vld  = 1'b0;
            ordy = 1'b0;
            ops  = '0;
            sub  = 1'b0;
            cin  = 1'b0;
            ca   = '0;
            cb   = '0;
            mask = {64{1'b1}} >> (64 - W);
            wait (s_rst_n === 1'b1);
            while (sent < NTX) begin
                @(posedge clk);
                #1;
                if (acc) begin
                    sent++;
                    vld = 1'b0;
                end
                if (!vld && sent < NTX && $urandom_range(0, 3) != 0) begin
                    ca  = pick(W, mask);
                    cb  = pick(W, mask);
                    sub = 1'($urandom_range(0, 1));
                    cin = 1'($urandom_range(0, 1));
                    t   = pack(W, ca, cb);
                    ops = t[2*W-1:0];
                    vld = 1'b1;
                end
                ordy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = vld && rdy;
            end
            vld  = 1'b0;
            ordy = 1'b1;
            for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
            chk($sformatf("w%0d_drain", W), q.size(), 0);
            done_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int   lat;
        int   sent;
        int   base;
        logic acc;

        rst_n = 1'b0;
        m_vld = 1'b0; m_ordy = 1'b0; m_ops = '0; m_sub = 1'b0; m_cin = 1'b0; m_a = '0; m_b = '0;
        n_vld = 1'b0; n_ordy = 1'b0; n_ops = '0; n_sub = 1'b0; n_cin = 1'b0;
        #12;
        chk("reset_out_valid", m_ovld, 0);
        chk("reset_out_sum", m_sum, 0);
        chk("reset_out_ovf", m_ovf, 0);
        chk("reset_in_ready", m_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-computed results
        directed(12'hFFF, 12'h001, 1'b0, 1'b0, 13'h1000, 1'b0, "add_fff_1");
        directed(12'h005, 12'h007, 1'b1, 1'b0, 13'h0FFE, 1'b0, "sub_5_7");
        directed(12'h800, 12'h001, 1'b1, 1'b0, 13'h17FF, 1'b1, "sub_800_1");
        directed(12'h005, 12'h007, 1'b1, 1'b1, 13'h0FFE, 1'b0, "sub_cin_ignored");
        directed(12'h7FF, 12'h000, 1'b0, 1'b1, 13'h0800, 1'b1, "add_cin");
        directed(12'h800, 12'h800, 1'b0, 1'b0, 13'h1000, 1'b1, "add_neg_neg");

        // USE_CIN=0: carry-in ignored
        begin
            logic [127:0] t;
            @(posedge clk);
            #1;
            t      = pack(12, 64'h7FF, 64'h0);
            n_ops  = t[23:0];
            n_cin  = 1'b1;
            n_vld  = 1'b1;
            n_ordy = 1'b1;
            @(posedge clk);
            #1;
            n_vld = 1'b0;
            lat   = -1;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (n_ovld) begin
                    lat = k - 1;
                    break;
                end
            end
            chk("nocin_latency", lat, 3);
            chk("nocin_sum", n_sum, 13'h07FF);
            chk("nocin_ovf", n_ovf, 0);
        end

        // Stream of 8 with out_ready low in cycles 4..6
        base = m_outs;
        sent = 0;
        @(posedge clk);
        #1;
        m_ordy = 1'b1;
        drive_main(12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        m_vld = 1'b1;
        @(negedge clk);
        acc = m_vld && m_rdy;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (acc) sent++;
            m_ordy = !(k >= 4 && k <= 6);
            if (acc) begin
                if (sent < 8)
                    drive_main(12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    m_vld = 1'b0;
            end
            @(negedge clk);
            if (k >= 4 && k <= 6) chk("stream_in_ready_low", m_rdy, 0);
            acc = m_vld && m_rdy;
            if (sent == 8 && mq.size() == 0) break;
        end
        m_vld = 1'b0;
        chk("stream_count", m_outs - base, 8);

        // Reset with transactions in flight
        @(posedge clk);
        #1;
        m_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive_main(12'h123, 12'h456, 1'b0, 1'b0);
            else        drive_main(12'($urandom), 12'($urandom), 1'b0, 1'b0);
            m_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        m_vld = 1'b0;
        chk("rst_pre_valid", m_ovld, 1);
        chk("rst_pre_sum", m_sum, 13'h0579);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", m_ovld, 0);
        chk("rst_async_sum", m_sum, 0);
        chk("rst_async_ovf", m_ovf, 0);
        mq.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        directed(12'h0AB, 12'h101, 1'b0, 1'b0, 13'h01AC, 1'b0, "post_rst");
        @(posedge clk);
        #1;
        base = m_outs;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_alone", m_outs - base, 0);

        // Wait for the width sweep
        for (int t = 0; t < 60000 && done_cnt < 5; t++) @(posedge clk);
        chk("sweep_done", done_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/bk_adder_pipe.md
Name: bk_adder_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 12-bit Brent-Kung adder.
- Adds or subtracts two WIDTH-bit operands, with optional carry-in, through a Brent-Kung parallel-prefix carry network.
- The network is split across three register stages with a valid/ready handshake, so it closes timing at wide widths.
- Sits in the datapath wherever the combinational adder was used; operand packing is interleaved, as before.

Parameters:
- WIDTH, 12, operand width in bits; legal range 2..64.
- USE_CIN, 1, 1 = `cin` is honoured in add mode; 0 = `cin` is ignored and treated as 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_ops  input  2*WIDTH  interleaved operands: in_ops[2i]=a[i], in_ops[2i+1]=b[i].
- in_sub  input  1  0 = a+b+cin; 1 = a-b (computed as a+~b+1; cin ignored).
- cin  input  1  carry-in for add mode.
- in_valid  input  1  input transaction present.
- in_ready  output  1  pipeline can accept this cycle.
- out_sum  output  WIDTH+1  result; bit WIDTH is carry-out (in sub mode: 1 = no borrow).
- out_ovf  output  1  signed two's-complement overflow of the WIDTH-bit result.
- out_valid  output  1  out_sum/out_ovf are valid.
- out_ready  input  1  downstream accepts.

Behaviour:
Reset
- rst_n low clears all stage valid bits and all data registers immediately, regardless of clk.
- After reset: out_valid=0, out_sum=0, out_ovf=0, in_ready=1.
- In-flight transactions are discarded, never emitted.

Stages
- S1 registers the de-interleaved operands.
  - Effective b' = in_sub ? ~b : b.
  - Effective c0 = in_sub ? 1 : (USE_CIN ? cin : 0).
  - Registers per-bit generate g=a&b', propagate p=a^b', c0, and the operand MSBs a[W-1], b'[W-1].
- S2 registers the Brent-Kung up-sweep results: group (G,P) at bit positions 2^k-1 mod 2^(k+1), for all levels k.
- S3 performs the down-sweep, combines c0 into every prefix carry, and forms:
  - sum[i] = p[i]^c[i]
  - out_sum[WIDTH] = c[WIDTH]
  - out_ovf = c[WIDTH]^c[WIDTH-1]
- S3 is the output register.
- The prefix network must be generated for arbitrary WIDTH, non-power-of-two included; the tree is padded to the next power of two with g=0, p=0.

Latency and throughput
- Latency is exactly 3 cycles: a transaction accepted at edge N is presented with out_valid=1 after edge N+3, when there are no stalls.
- Throughput is 1 transaction/cycle.

Handshake
- Transfer occurs on a rising edge with in_valid&in_ready (input side) or out_valid&out_ready (output side).
- advance = ~out_valid | out_ready.
- in_ready = advance; it is combinational from out_ready.
- When advance=1, every stage shifts by one; a stage fed an invalid slot becomes invalid.
- When advance=0, all stages hold and out_sum/out_ovf/out_valid stay stable.
- Data registers of invalid slots may hold stale data, but out_sum and out_ovf must read 0 whenever out_valid=0.
- Acceptance at the input and a drain at the output in the same cycle are both honoured.
- There is no reordering and no dropping; the input-to-output order is preserved.

Width rules
- Operands are unsigned for out_sum and carry.
- out_ovf interprets the operands as signed.
- out_sum is zero-extended: it never sign-extends.

Test Plan:
1. WIDTH=12, add: a=0xFFF, b=0x001, cin=0. Required: out_sum=0x1000, out_ovf=0, out_valid rises exactly 3 cycles after acceptance.
2. Sub: a=5, b=7. Required: out_sum=0x0FFE (bit12=0, borrow), out_ovf=0. Then a=0x800, b=1. Required: out_sum=0x17FF, out_ovf=1.
3. Add with carry-in:
   - USE_CIN=1: a=0x7FF, b=0, cin=1. Required: out_sum=0x0800, out_ovf=1.
   - USE_CIN=0, same stimulus. Required: out_sum=0x07FF, out_ovf=0.
4. Back-to-back stream of 8 random pairs, with out_ready held low for cycles 4..6.
   - in_ready must be low in those cycles and outputs must be stable.
   - All 8 results must emerge in order and match the reference model, with no loss or duplication.
5. Reset mid-stream: assert rst_n low asynchronously between edges with 3 transactions in flight.
   - out_valid and out_sum must go to 0 immediately.
   - After release, the next accepted transaction must emerge alone, 3 cycles later.
6. Parameter sweep WIDTH=2,7,12,32,64, with 10k random add/sub transactions and random out_ready. Required: exact match against a+b'+c0 on WIDTH+1 bits, and against the signed-overflow formula.
